rsa_ctrl_seq: RTL and testbench

Parametrised control sequencer for the RSA unit. It arbitrates NUM_SRC start/stop request sources (GPIO, SPI, others), holds the RSA unit in reset for a programmable number of cycles, and enables the unit while it runs. It waits for the unit's end-of-conversion, with an optional watchdog timeout. It reports completion to host interfaces as both a sticky level and a one-cycle pulse.

---
 rtl/rsa_ctrl_seq.sv | 133 +++++++++++++
 tb/tb_rsa_ctrl_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rsa_ctrl_seq.sv
// Control sequencer for the RSA unit: arbitrates start/stop sources, pulses the unit reset,
// runs it under an optional watchdog and reports completion as a sticky level plus a pulse.
module rsa_ctrl_seq #(
   parameter int NUM_SRC    = 2,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT_W  = 16,
   localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 ena,
   input  logic [NUM_SRC-1:0]   start_req,
   input  logic [NUM_SRC-1:0]   stop_req,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 eoc_rsa_unit,
   output logic                 en_rsa,
   output logic                 rst_rsa,
   output logic                 busy,
   output logic                 eoc,
   output logic                 eoc_p,
   output logic                 timeout_flag,
   output logic [SRC_W-1:0]     src_id
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [RST_W-1:0]     rst_cnt_reg, rst_cnt_next;
   logic [TIMEOUT_W-1:0] run_cnt_reg, run_cnt_next;
   logic [TIMEOUT_W-1:0] limit_reg, limit_next;
   logic                 eoc_reg, eoc_next;
   logic                 timeout_reg, timeout_next;
   logic [SRC_W-1:0]     src_id_reg, src_id_next;
   logic [SRC_W-1:0]     src_sel;
   logic                 any_stop;

   assign any_stop = |stop_req;

   // Lowest set request index wins.
   always_comb begin
      src_sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (start_req[i]) src_sel = SRC_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_reg   <= IDLE;
         rst_cnt_reg <= '0;
         run_cnt_reg <= '0;
         limit_reg   <= '0;
         eoc_reg     <= 1'b0;
         timeout_reg <= 1'b0;
         src_id_reg  <= '0;
      end else if (ena) begin
         state_reg   <= state_next;
         rst_cnt_reg <= rst_cnt_next;
         run_cnt_reg <= run_cnt_next;
         limit_reg   <= limit_next;
         eoc_reg     <= eoc_next;
         timeout_reg <= timeout_next;
         src_id_reg  <= src_id_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rst_cnt_next = rst_cnt_reg;
      run_cnt_next = run_cnt_reg;
      limit_next   = limit_reg;
      eoc_next     = eoc_reg;
      timeout_next = timeout_reg;
      src_id_next  = src_id_reg;
      unique case (state_reg)
         IDLE: begin
            if ((|start_req) && !any_stop) begin
               state_next   = CLR;
               src_id_next  = src_sel;
               limit_next   = timeout_limit;
               eoc_next     = 1'b0;
               timeout_next = 1'b0;
               rst_cnt_next = '0;
            end
         end
         CLR: begin
            if (any_stop) begin
               state_next = IDLE;
            end else if (rst_cnt_reg == RST_LAST) begin
               state_next   = RUN;
               run_cnt_next = '0;
            end else begin
               rst_cnt_next = rst_cnt_reg + 1'b1;
            end
         end
         RUN: begin
            if (any_stop) begin
               state_next = IDLE;
            end else if (eoc_rsa_unit) begin
               state_next = DONE;
               eoc_next   = 1'b1;
            end else if ((limit_reg != '0) && (run_cnt_reg == limit_reg - TIMEOUT_W'(1))) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end else if (run_cnt_reg != '1) begin
               // Saturate so an unbounded wait never wraps.
               run_cnt_next = run_cnt_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign en_rsa       = (state_reg != IDLE);
   assign busy         = (state_reg != IDLE);
   assign rst_rsa      = (state_reg != CLR);
   assign eoc_p        = (state_reg == DONE);
   assign eoc          = eoc_reg;
   assign timeout_flag = timeout_reg;
   assign src_id       = src_id_reg;

endmodule

// File: tb/tb_rsa_ctrl_seq.sv
// Directed bench for rsa_ctrl_seq: hand-derived cycle-by-cycle expectations per scenario.
module tb_rsa_ctrl_seq;

   logic        clk = 1'b0;
   logic        rstb;
   logic        ena;
   logic [1:0]  start_req;
   logic [1:0]  stop_req;
   logic [15:0] timeout_limit;
   logic        eoc_rsa_unit;
   logic        en_rsa, rst_rsa, busy, eoc, eoc_p, timeout_flag;
   logic [0:0]  src_id;

   int n_vec  = 0;
   int n_miss = 0;

   rsa_ctrl_seq #(.NUM_SRC(2), .RST_CYCLES(2), .TIMEOUT_W(16)) dut (
      .clk           (clk),
      .rstb          (rstb),
      .ena           (ena),
      .start_req     (start_req),
      .stop_req      (stop_req),
      .timeout_limit (timeout_limit),
      .eoc_rsa_unit  (eoc_rsa_unit),
      .en_rsa        (en_rsa),
      .rst_rsa       (rst_rsa),
      .busy          (busy),
      .eoc           (eoc),
      .eoc_p         (eoc_p),
      .timeout_flag  (timeout_flag),
      .src_id        (src_id)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h @%0t", tag, got, $time);
      end
   endtask

   // Advance one active edge; outputs are then sampled 1 time unit later.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_op(input logic [1:0] req, input logic [15:0] lim);
      start_req     = req;
      timeout_limit = lim;
      tick();
      start_req = 2'b00;
   endtask

   int run_cycles;
   logic saw_eoc_p;

   initial begin
      rstb = 1'b0; ena = 1'b1; start_req = '0; stop_req = '0;
      timeout_limit = '0; eoc_rsa_unit = 1'b0;
      #2;
      check_val("rst_busy",   busy, 0);
      check_val("rst_rst_rsa", rst_rsa, 1);
      check_val("rst_src_id", src_id, 0);
      tick(2);
      rstb = 1'b1;
      tick();

      // Normal operation
      start_op(2'b10, 16'd0);
      check_val("norm_c1_en",  en_rsa, 1);
      check_val("norm_c1_rst", rst_rsa, 0);
      tick();
      check_val("norm_c2_rst", rst_rsa, 0);
      tick();
      check_val("norm_c3_run_rst", rst_rsa, 1);
      check_val("norm_c3_run_en",  en_rsa, 1);
      tick(6);
      eoc_rsa_unit = 1'b1;
      tick();
      eoc_rsa_unit = 1'b0;
      check_val("norm_eoc_p", eoc_p, 1);
      check_val("norm_eoc",   eoc, 1);
      tick();
      check_val("norm_idle_eoc_p", eoc_p, 0);
      check_val("norm_idle_eoc",   eoc, 1);
      check_val("norm_idle_busy",  busy, 0);
      check_val("norm_src_id",     src_id, 1);

      // Watchdog
      start_op(2'b01, 16'd5);
      check_val("wd_eoc_cleared", eoc, 0);
      tick(2);
      run_cycles = 0; saw_eoc_p = 1'b0;
      while (busy && run_cycles < 50) begin
         run_cycles++;
         if (eoc_p) saw_eoc_p = 1'b1;
         tick();
      end
      check_val("wd_run_cycles", run_cycles, 5);
      check_val("wd_flag",       timeout_flag, 1);
      check_val("wd_eoc",        eoc, 0);
      check_val("wd_no_eoc_p",   saw_eoc_p, 0);
      start_op(2'b01, 16'd0);
      check_val("wd_flag_clr", timeout_flag, 0);
      stop_req = 2'b01; tick(); stop_req = 2'b00;
      check_val("wd_abort_clr", busy, 0);

      // Abort priority over end-of-conversion
      start_op(2'b01, 16'd0);
      tick(3);
      stop_req = 2'b01; eoc_rsa_unit = 1'b1;
      tick();
      stop_req = 2'b00; eoc_rsa_unit = 1'b0;
      check_val("abort_busy",  busy, 0);
      check_val("abort_eoc",   eoc, 0);
      check_val("abort_eoc_p", eoc_p, 0);
      start_req = 2'b01; stop_req = 2'b10;
      tick();
      start_req = 2'b00; stop_req = 2'b00;
      check_val("startstop_idle", busy, 0);

      // Enable gating during CLR
      start_op(2'b01, 16'd0);
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val($sformatf("gate_frozen%0d", i), rst_rsa, 0);
      end
      ena = 1'b1;
      tick();
      check_val("gate_clr2", rst_rsa, 0);
      tick();
      check_val("gate_run", rst_rsa, 1);

      // eoc_p held while frozen in DONE
      eoc_rsa_unit = 1'b1; tick(); eoc_rsa_unit = 1'b0;
      ena = 1'b0; tick(3);
      check_val("done_frozen_eoc_p", eoc_p, 1);
      ena = 1'b1; tick();
      check_val("done_release_eoc_p", eoc_p, 0);
      check_val("done_release_busy",  busy, 0);

      // Arbitration and ignored starts
      start_op(2'b11, 16'd0);
      check_val("arb_src_id", src_id, 0);
      tick(2);
      start_req = 2'b10; tick(); start_req = 2'b00;
      eoc_rsa_unit = 1'b1; tick(); eoc_rsa_unit = 1'b0;
      check_val("arb_done", eoc_p, 1);
      check_val("arb_src_kept", src_id, 0);
      tick();
      check_val("arb_idle", busy, 0);
      tick(3);
      check_val("arb_no_restart", busy, 0);

      // Asynchronous reset mid-RUN
      start_op(2'b10, 16'd0);
      tick(4);
      check_val("ar_pre_busy", busy, 1);
      #2 rstb = 1'b0;
      #1;
      check_val("ar_en",   en_rsa, 0);
      check_val("ar_rst",  rst_rsa, 1);
      check_val("ar_busy", busy, 0);
      check_val("ar_eoc",  eoc, 0);
      check_val("ar_tmo",  timeout_flag, 0);
      check_val("ar_src",  src_id, 0);
      tick();
      rstb = 1'b1;
      tick(3);
      check_val("ar_stay_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
